// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FSM state encoding and word-geometry constants for the instruction-memory loader.
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int BYTES_PER_WORD = DEF_DATA_WIDTH / 8;
  function automatic int bytes_per_word(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/byte_packer.sv
// byte_packer: byte index counter and little-endian assembly register; full is the word including the byte on byte_in.
module byte_packer
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  accept,
  input  logic [7:0]            byte_in,
  output logic [DATA_WIDTH-1:0] full,
  output logic                  last
);
  localparam int BPW = bytes_per_word(DATA_WIDTH);
  localparam int IW = BPW > 1 ? $clog2(BPW) : 1;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] sr;
  assign last = idx == IW'(BPW - 1);
  // new bytes enter at the top, so after BPW bytes the first one sits in [7:0]
  assign full = (sr >> 8) | (DATA_WIDTH'(byte_in) << (DATA_WIDTH - 8));
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      idx <= '0;
      sr  <= '0;
    end else if (accept) begin
      idx <= last ? '0 : idx + 1'b1;
      sr  <= full;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams bytes into full little-endian words and writes them to sequential memory addresses.
// Optional macro IMEM_LOADER_CHECKSUM_EN enables the modulo-256 byte checksum on o_checksum.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = BYTES_PER_WORD * 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH:0]   i_word_count,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte,
  output logic                  o_byte_ready,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic [DATA_WIDTH-1:0] o_di,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [7:0]            o_checksum
);
  localparam logic [ADDR_WIDTH:0] CAP = {1'b1, {ADDR_WIDTH{1'b0}}};
  state_t                state, nxt;
  logic [ADDR_WIDTH:0]   cnt, cnt_in;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] full;
  logic                  start_ok, accept, last, last_word;
  assign start_ok  = i_start && (state == IDLE || state == DONE);
  assign accept    = i_byte_valid && o_byte_ready;
  assign cnt_in    = i_word_count > CAP ? CAP : i_word_count;
  assign last_word = {1'b0, addr} + (ADDR_WIDTH + 1)'(1) == cnt;
  byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clk    (clk),
    .rst_n  (i_rst_n),
    .clr    (start_ok),
    .accept (accept),
    .byte_in(i_byte),
    .full   (full),
    .last   (last)
  );
  always_comb begin
    nxt = start_ok           ? (cnt_in == '0 ? DONE : COLLECT)
        : state == COLLECT   ? (accept && last ? WRITE : COLLECT)
        : state == WRITE     ? (last_word ? DONE : COLLECT)
        : state;
  end
  // outputs are registered from the next state so they line up with the state register
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      addr         <= '0;
      o_we         <= 1'b0;
      o_byte_ready <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_waddr      <= '0;
      o_di         <= '0;
    end else begin
      state        <= nxt;
      o_we         <= nxt == WRITE;
      o_byte_ready <= nxt == COLLECT;
      o_busy       <= nxt == COLLECT || nxt == WRITE;
      o_done       <= nxt == DONE;
      if (start_ok) begin
        cnt  <= cnt_in;
        addr <= '0;
      end else if (state == WRITE && !last_word) begin
        addr <= addr + 1'b1;
      end
      if (accept && last) begin
        o_waddr <= addr;
        o_di    <= full;
      end
    end
  end
`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!i_rst_n || start_ok) o_checksum <= '0;
    else if (accept) o_checksum <= o_checksum + i_byte;
  end
`else
  assign o_checksum = '0;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader with hand-computed words, addresses and checksums.
module tb_imem_loader;
  import cpu_pkg::*;
  localparam int AW = 8;
  localparam int DW = 32;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif
  logic          clk = 1'b0;
  logic          i_rst_n, i_start, i_byte_valid;
  logic [AW:0]   i_word_count;
  logic [7:0]    i_byte;
  logic          o_byte_ready, o_we, o_busy, o_done;
  logic [AW-1:0] o_waddr;
  logic [DW-1:0] o_di;
  logic [7:0]    o_checksum;
  int total = 0, bad = 0, we_cnt = 0, rdy_in_wr = 0;
  bit ever_ready = 0, cs_seen = 0;
  logic [AW+DW-1:0] wq [0:511];
  logic [7:0]       src [0:1023];

  always #5 clk = ~clk;

  imem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_word_count(i_word_count),
    .i_byte_valid(i_byte_valid),
    .i_byte      (i_byte),
    .o_byte_ready(o_byte_ready),
    .o_we        (o_we),
    .o_waddr     (o_waddr),
    .o_di        (o_di),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_checksum  (o_checksum)
  );

  always @(negedge clk) begin
    if (o_we) begin
      if (we_cnt < 512) wq[we_cnt] = {o_waddr, o_di};
      we_cnt++;
      if (o_byte_ready) rdy_in_wr++;
    end
    if (o_byte_ready) ever_ready = 1'b1;
    if (o_checksum != 8'h00) cs_seen = 1'b1;
  end

  task automatic start(input int n);
    @(posedge clk); #1;
    i_start = 1'b1;
    i_word_count = (AW + 1)'(n);
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic feed(input int n, input bit toggle, input int sp);
    int k = 0, cyc = 0;
    bit acc, ph = 1'b1;
    while (k < n && cyc < n * 4 + 50) begin
      i_byte_valid = toggle ? ph : 1'b1;
      i_byte = src[k];
      i_start = (k == sp);
      i_word_count = 9'd1;
      acc = i_byte_valid && o_byte_ready;
      @(posedge clk); #1;
      if (acc) k++;
      ph = ~ph;
      cyc++;
    end
    i_byte_valid = 1'b0;
    i_start = 1'b0;
    total++;
    if (k != n) begin bad++; $display("FAIL feed: accepted=%0d required=%0d", k, n); end
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (!o_done && c < budget) begin @(posedge clk); #1; c++; end
    total++;
    if (o_done !== 1'b1) begin bad++; $display("FAIL wait_done: o_done=%b required=1 after %0d cycles", o_done, c); end
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0; i_start = 1'b0; i_word_count = '0; i_byte_valid = 1'b0; i_byte = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({o_we, o_byte_ready, o_busy, o_done, o_waddr, o_di, o_checksum} !== '0) begin
      bad++;
      $display("FAIL reset: we=%b rdy=%b busy=%b done=%b addr=%h di=%h cs=%h required all 0",
               o_we, o_byte_ready, o_busy, o_done, o_waddr, o_di, o_checksum);
    end
    i_rst_n = 1'b1;
  endtask

  task automatic test_two_words;
    int base = we_cnt;
    cs_seen = 1'b0;
    for (int i = 0; i < 8; i++) src[i] = 8'((i + 1) * 8'h11);
    start(2);
    feed(8, 1'b0, -1);
    wait_done(10);
    total++;
    if (we_cnt - base != 2) begin bad++; $display("FAIL two_words count: got=%0d required=2", we_cnt - base); end
    total++;
    if (wq[base] !== {8'd0, 32'h44332211}) begin bad++; $display("FAIL two_words w0: got=%h required=%h", wq[base], {8'd0, 32'h44332211}); end
    total++;
    if (wq[base+1] !== {8'd1, 32'h88776655}) begin bad++; $display("FAIL two_words w1: got=%h required=%h", wq[base+1], {8'd1, 32'h88776655}); end
    total++;
    if ({o_busy, o_we, o_byte_ready} !== 3'b000) begin bad++; $display("FAIL two_words idle: busy/we/rdy=%b required=000", {o_busy, o_we, o_byte_ready}); end
    total++;
    if (o_checksum !== (CS_EN ? 8'h64 : 8'h00)) begin bad++; $display("FAIL two_words checksum: got=%h required=%h", o_checksum, CS_EN ? 8'h64 : 8'h00); end
`ifndef IMEM_LOADER_CHECKSUM_EN
    total++;
    if (cs_seen !== 1'b0) begin bad++; $display("FAIL checksum_off: nonzero checksum seen=%b required=0", cs_seen); end
`endif
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (o_done !== 1'b1 || o_waddr !== 8'd1 || o_di !== 32'h88776655) begin
      bad++; $display("FAIL done_hold: done=%b addr=%h di=%h required 1/01/88776655", o_done, o_waddr, o_di);
    end
  endtask

  task automatic test_toggle_valid;
    int base = we_cnt, rw = rdy_in_wr;
    src[0] = 8'hA1; src[1] = 8'hB2; src[2] = 8'hC3; src[3] = 8'hD4;
    start(1);
    feed(4, 1'b1, -1);
    wait_done(10);
    total++;
    if (we_cnt - base != 1) begin bad++; $display("FAIL toggle count: got=%0d required=1", we_cnt - base); end
    total++;
    if (wq[base] !== {8'd0, 32'hD4C3B2A1}) begin bad++; $display("FAIL toggle word: got=%h required=%h", wq[base], {8'd0, 32'hD4C3B2A1}); end
    total++;
    if (rdy_in_wr != rw) begin bad++; $display("FAIL toggle ready_in_write: got=%0d required=0", rdy_in_wr - rw); end
    total++;
    if (o_checksum !== (CS_EN ? 8'hEA : 8'h00)) begin bad++; $display("FAIL toggle checksum: got=%h required=%h", o_checksum, CS_EN ? 8'hEA : 8'h00); end
  endtask

  task automatic test_zero_count;
    int base = we_cnt;
    @(posedge clk); #1;
    ever_ready = 1'b0;
    i_start = 1'b1; i_word_count = '0;
    @(posedge clk); #1;
    i_start = 1'b0;
    total++;
    if ({o_done, o_busy} !== 2'b10) begin bad++; $display("FAIL zero done: done/busy=%b required=10", {o_done, o_busy}); end
    total++;
    if (o_checksum !== 8'h00) begin bad++; $display("FAIL zero checksum: got=%h required=00", o_checksum); end
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (we_cnt != base || ever_ready) begin bad++; $display("FAIL zero quiet: writes=%0d ready_seen=%b required 0/0", we_cnt - base, ever_ready); end
  endtask

  task automatic test_mid_reset;
    int base = we_cnt;
    for (int i = 0; i < 4; i++) src[i] = 8'hE0 + 8'(i);
    start(1);
    feed(3, 1'b0, -1);
    i_rst_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({o_we, o_byte_ready, o_busy, o_done, o_waddr, o_di, o_checksum} !== '0) begin
      bad++;
      $display("FAIL mid_reset outputs: we=%b rdy=%b busy=%b done=%b addr=%h di=%h cs=%h required all 0",
               o_we, o_byte_ready, o_busy, o_done, o_waddr, o_di, o_checksum);
    end
    i_rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (we_cnt != base) begin bad++; $display("FAIL mid_reset write: got=%0d required=0", we_cnt - base); end
    for (int i = 0; i < 4; i++) src[i] = 8'(i + 1);
    start(1);
    feed(4, 1'b0, -1);
    wait_done(10);
    total++;
    if (we_cnt - base != 1 || wq[base] !== {8'd0, 32'h04030201}) begin
      bad++; $display("FAIL mid_reset reload: writes=%0d word=%h required 1/%h", we_cnt - base, wq[base], {8'd0, 32'h04030201});
    end
    total++;
    if (o_checksum !== (CS_EN ? 8'h0A : 8'h00)) begin bad++; $display("FAIL mid_reset checksum: got=%h required=%h", o_checksum, CS_EN ? 8'h0A : 8'h00); end
  endtask

  task automatic test_saturate;
    int base = we_cnt, errs = 0;
    logic [7:0] sum = 8'h00;
    logic [AW+DW-1:0] exp;
    for (int k = 0; k < 1024; k++) begin
      src[k] = 8'(k * 7 + 3);
      sum += src[k];
    end
    start(300);
    feed(1024, 1'b0, 500);
    wait_done(10);
    total++;
    if (we_cnt - base != 256) begin bad++; $display("FAIL saturate count: got=%0d required=256", we_cnt - base); end
    for (int i = 0; i < 256; i++) begin
      exp = {8'(i), src[4*i+3], src[4*i+2], src[4*i+1], src[4*i]};
      if (wq[base+i] !== exp) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL saturate words: wrong=%0d required=0", errs); end
    total++;
    if (o_checksum !== (CS_EN ? sum : 8'h00)) begin bad++; $display("FAIL saturate checksum: got=%h required=%h", o_checksum, CS_EN ? sum : 8'h00); end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (we_cnt - base != 256 || o_byte_ready !== 1'b0) begin
      bad++; $display("FAIL saturate stop: writes=%0d rdy=%b required 256/0", we_cnt - base, o_byte_ready);
    end
  endtask

  initial begin
    test_reset;
    test_two_words;
    test_toggle_valid;
    test_zero_count;
    test_mid_reset;
    test_saturate;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
